// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage RV32 core: stall/flush generation for the
// PC and the four stage registers, bounded data-memory wait, and a stall-cycle counter.

module pipeline_hazard_ctrl_chk (
  input logic clock,
  input logic resetn,
  input logic pc_stall,
  input logic if_id_stall,
  input logic if_id_flush,
  input logic id_ex_stall,
  input logic id_ex_flush,
  input logic ex_mem_stall,
  input logic ex_mem_flush,
  input logic mem_wb_stall,
  input logic mem_wb_flush,
  input logic mem_timeout
);

  // A stage register must never be told to hold and to squash in the same cycle.
  a_if_id_excl : assert property (@(posedge clock) disable iff (!resetn)
    !(if_id_stall && if_id_flush));
  a_id_ex_excl : assert property (@(posedge clock) disable iff (!resetn)
    !(id_ex_stall && id_ex_flush));
  a_ex_mem_excl : assert property (@(posedge clock) disable iff (!resetn)
    !(ex_mem_stall && ex_mem_flush));
  a_mem_wb_excl : assert property (@(posedge clock) disable iff (!resetn)
    !(mem_wb_stall && mem_wb_flush));
  a_timeout_flush : assert property (@(posedge clock) disable iff (!resetn)
    mem_timeout |-> (mem_wb_flush && ex_mem_flush && !pc_stall));

endmodule

module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken_ex,
  input  logic             exception,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_wb_stall,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int                WAIT_W    = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_s;
  logic [CNT_W-1:0]  stall_count_r;

  logic mem_miss_s;
  logic rs1_hit_s;
  logic rs2_hit_s;
  logic load_use_s;

  logic pc_stall_s;
  logic if_id_stall_s;
  logic if_id_flush_s;
  logic id_ex_stall_s;
  logic id_ex_flush_s;
  logic ex_mem_stall_s;
  logic ex_mem_flush_s;
  logic mem_wb_stall_s;
  logic mem_wb_flush_s;
  logic mem_timeout_s;

  assign mem_miss_s = mem_req & ~mem_ready;
  assign rs1_hit_s  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit_s  = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use_s = ex_mem_read & (ex_rd != 5'd0) & (rs1_hit_s | rs2_hit_s);

  // Next-state, wait counter and raw stall/flush decode.
  always_comb begin
    state_s        = state_r;
    wait_cnt_s     = wait_cnt_r;
    pc_stall_s     = 1'b0;
    if_id_stall_s  = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_stall_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_stall_s = 1'b0;
    ex_mem_flush_s = 1'b0;
    mem_wb_stall_s = 1'b0;
    mem_wb_flush_s = 1'b0;
    mem_timeout_s  = 1'b0;
    case (state_r)
      RUN: begin
        if (exception) begin
          if_id_flush_s  = 1'b1;
          id_ex_flush_s  = 1'b1;
          ex_mem_flush_s = 1'b1;
          state_s        = TRAP;
        end else if (mem_miss_s) begin
          pc_stall_s     = 1'b1;
          if_id_stall_s  = 1'b1;
          id_ex_stall_s  = 1'b1;
          ex_mem_stall_s = 1'b1;
          mem_wb_flush_s = 1'b1;
          state_s        = MEM_WAIT;
          wait_cnt_s     = WAIT_ONE;
        end else if (branch_taken_ex) begin
          // The ID instruction is wrong-path, so any load-use stall it implies is dropped.
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
        end else if (load_use_s) begin
          pc_stall_s    = 1'b1;
          if_id_stall_s = 1'b1;
          id_ex_flush_s = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_s    = RUN;
          wait_cnt_s = WAIT_ZERO;
        end else if (wait_cnt_r < WAIT_LAST) begin
          pc_stall_s     = 1'b1;
          if_id_stall_s  = 1'b1;
          id_ex_stall_s  = 1'b1;
          ex_mem_stall_s = 1'b1;
          mem_wb_flush_s = 1'b1;
          wait_cnt_s     = wait_cnt_r + WAIT_ONE;
        end else begin
          mem_timeout_s  = 1'b1;
          if_id_flush_s  = 1'b1;
          id_ex_flush_s  = 1'b1;
          ex_mem_flush_s = 1'b1;
          mem_wb_flush_s = 1'b1;
          state_s        = TRAP;
          wait_cnt_s     = WAIT_ZERO;
        end
      end
      TRAP: begin
        // Extra IF/ID squash covers the fetch-redirect latency.
        if_id_flush_s = 1'b1;
        state_s       = RUN;
      end
      default: begin
        state_s    = RUN;
        wait_cnt_s = WAIT_ZERO;
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r    <= RUN;
      wait_cnt_r <= WAIT_ZERO;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // Saturating count of PC-stall cycles.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_count_r <= CNT_ZERO;
    end else if (pc_stall && (stall_count_r != CNT_MAX)) begin
      stall_count_r <= stall_count_r + CNT_ONE;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  // Gating with resetn drops every control line the instant reset asserts.
  assign pc_stall     = resetn & pc_stall_s;
  assign if_id_stall  = resetn & if_id_stall_s;
  assign if_id_flush  = resetn & if_id_flush_s;
  assign id_ex_stall  = resetn & id_ex_stall_s;
  assign id_ex_flush  = resetn & id_ex_flush_s;
  assign ex_mem_stall = resetn & ex_mem_stall_s;
  assign ex_mem_flush = resetn & ex_mem_flush_s;
  assign mem_wb_stall = resetn & mem_wb_stall_s;
  assign mem_wb_flush = resetn & mem_wb_flush_s;
  assign mem_timeout  = resetn & mem_timeout_s;
  assign stall_count  = stall_count_r;

  pipeline_hazard_ctrl_chk u_chk (
    .clock        (clock),
    .resetn       (resetn),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_stall (mem_wb_stall),
    .mem_wb_flush (mem_wb_flush),
    .mem_timeout  (mem_timeout)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl, built with MAX_WAIT=4 and CNT_W=4
// so that timeout and counter saturation are reached in a few cycles.

module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  // Output vector order: pc_stall, if_id_{stall,flush}, id_ex_{stall,flush},
  // ex_mem_{stall,flush}, mem_wb_{stall,flush}, mem_timeout.
  localparam logic [9:0] O_NONE = 10'b00_0000_0000;
  localparam logic [9:0] O_LU   = 10'b11_0010_0000;
  localparam logic [9:0] O_BR   = 10'b00_1010_0000;
  localparam logic [9:0] O_EXC  = 10'b00_1010_1000;
  localparam logic [9:0] O_MISS = 10'b11_0101_0010;
  localparam logic [9:0] O_TMO  = 10'b00_1010_1011;
  localparam logic [9:0] O_TRAP = 10'b00_1000_0000;

  logic             clock;
  logic             resetn;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             branch_taken_ex;
  logic             exception;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             ex_mem_flush;
  logic             mem_wb_stall;
  logic             mem_wb_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [9:0]       outs;

  int checks;
  int failures;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .branch_taken_ex (branch_taken_ex),
    .exception       (exception),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_stall    (ex_mem_stall),
    .ex_mem_flush    (ex_mem_flush),
    .mem_wb_stall    (mem_wb_stall),
    .mem_wb_flush    (mem_wb_flush),
    .mem_timeout     (mem_timeout),
    .stall_count     (stall_count)
  );

  assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                 ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush, mem_timeout};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [9:0] exp);
    #1;
    check_eq(tag, {22'd0, outs}, {22'd0, exp});
  endtask

  task automatic expect_cnt(input string tag, input logic [CNT_W-1:0] exp);
    #1;
    check_eq(tag, {28'd0, stall_count}, {28'd0, exp});
  endtask

  task automatic idle_inputs();
    id_rs1          = 5'd0;
    id_rs2          = 5'd0;
    id_uses_rs1     = 1'b0;
    id_uses_rs2     = 1'b0;
    ex_mem_read     = 1'b0;
    ex_rd           = 5'd0;
    branch_taken_ex = 1'b0;
    exception       = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b0;
  endtask

  task automatic set_load_use_rs2();
    ex_mem_read = 1'b1;
    ex_rd       = 5'd5;
    id_rs2      = 5'd5;
    id_uses_rs2 = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    resetn = 1'b0;

    // Reset: outputs forced low even with a load-use pattern present.
    set_load_use_rs2();
    repeat (2) @(posedge clock);
    #1;
    expect_out("reset_outs", O_NONE);
    expect_cnt("reset_cnt", 4'd0);
    do_reset();

    // Load-use via rs2, then rd=x0, rs1 path, and the uses_rs1 qualifier.
    set_load_use_rs2();
    expect_out("lu_rs2", O_LU);
    tick();
    idle_inputs();
    expect_out("lu_rs2_after", O_NONE);
    expect_cnt("lu_rs2_cnt", 4'd1);
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    expect_out("lu_rd_x0", O_NONE);
    tick();
    expect_cnt("lu_rd_x0_cnt", 4'd1);
    idle_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    expect_out("lu_rs1", O_LU);
    tick();
    expect_cnt("lu_rs1_cnt", 4'd2);
    id_uses_rs1 = 1'b0;
    expect_out("lu_rs1_unused", O_NONE);
    id_uses_rs1 = 1'b1; ex_mem_read = 1'b0;
    expect_out("lu_not_load", O_NONE);

    // Branch with load-use pending: branch wins and state stays RUN.
    ex_mem_read = 1'b1; branch_taken_ex = 1'b1;
    expect_out("br_over_lu", O_BR);
    tick();
    expect_cnt("br_cnt", 4'd2);
    branch_taken_ex = 1'b0;
    expect_out("br_then_lu", O_LU);
    tick();
    expect_cnt("br_then_lu_cnt", 4'd3);

    // Memory miss lasting 3 cycles, then ready.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("miss_c%0d", i), O_MISS);
      tick();
    end
    mem_ready = 1'b1;
    expect_out("miss_ready", O_NONE);
    tick();
    idle_inputs();
    expect_out("miss_back_run", O_NONE);
    expect_cnt("miss_cnt", 4'd3);

    // Timeout: 3 stall cycles, timeout pulse, one TRAP cycle, then RUN.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("tmo_stall_c%0d", i), O_MISS);
      tick();
    end
    expect_out("tmo_pulse", O_TMO);
    tick();
    expect_out("tmo_trap", O_TRAP);
    tick();
    expect_out("tmo_run_miss", O_MISS);
    mem_req = 1'b0;
    expect_out("tmo_run_idle", O_NONE);
    expect_cnt("tmo_cnt", 4'd3);

    // Exception has priority over a miss in RUN.
    do_reset();
    exception = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    expect_out("exc_over_miss", O_EXC);
    tick();
    idle_inputs();
    expect_out("exc_trap", O_TRAP);
    tick();

    // Exception, branch and load-use ignored in MEM_WAIT; exception taken after ready.
    mem_req = 1'b1; mem_ready = 1'b0;
    expect_out("mw_enter", O_MISS);
    tick();
    exception = 1'b1; branch_taken_ex = 1'b1;
    set_load_use_rs2();
    expect_out("mw_ignore", O_MISS);
    tick();
    branch_taken_ex = 1'b0; ex_mem_read = 1'b0; mem_ready = 1'b1;
    expect_out("mw_ready_exc", O_NONE);
    tick();
    mem_req = 1'b0;
    expect_out("mw_exc_run", O_EXC);
    tick();
    exception = 1'b0;
    expect_out("mw_exc_trap", O_TRAP);
    tick();
    expect_out("mw_exc_done", O_NONE);

    // Counter saturation over 20 load-use stall cycles.
    do_reset();
    set_load_use_rs2();
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    expect_out("sat_still_lu", O_LU);
    expect_cnt("sat_cnt", 4'd15);

    // Asynchronous reset mid-wait clears everything at once.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();
    tick();
    expect_out("arst_pre", O_MISS);
    expect_cnt("arst_pre_cnt", 4'd2);
    resetn = 1'b0;
    expect_out("arst_outs", O_NONE);
    expect_cnt("arst_cnt", 4'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    // A full fresh wait window proves wait_cnt was cleared.
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("arst_stall_c%0d", i), O_MISS);
      tick();
    end
    expect_out("arst_tmo", O_TMO);
    tick();
    idle_inputs();
    expect_out("arst_trap", O_TRAP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
